aes_sbox_sched: RTL

AES_SBOX_SCHED -- requirements
Module: aes_sbox_sched

---
 rtl/aes_sbox_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/aes_sbox_sched.sv
// Shared four-lane AES S-box serving the round-state SubBytes and the key-schedule SubWord.
// The S-box is computed as the GF(2^8) inverse followed by the affine transform.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse and maps 0 to 0, as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, x);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_sbox_sched #(
  parameter int FIRST_PRIO = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_gnt,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_gnt,
  output logic         kw_done,
  output logic [31:0]  kw_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ST_RUN, KW_RUN} state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] st_op_q, st_op_d;
  logic [31:0]  kw_op_q, kw_op_d;
  logic [127:0] st_out_q, st_out_d;
  logic [31:0]  kw_out_q, kw_out_d;
  logic         st_done_q, st_done_d;
  logic         kw_done_q, kw_done_d;
  logic         last_kw_q, last_kw_d;
  logic         idle_ok;
  logic [31:0]  lane_in;
  logic [31:0]  lane_out;

  always_comb begin
    lane_in = kw_op_q;
    if (state_q != KW_RUN) begin
      case (cnt_q)
        2'd0:    lane_in = st_op_q[31:0];
        2'd1:    lane_in = st_op_q[63:32];
        2'd2:    lane_in = st_op_q[95:64];
        default: lane_in = st_op_q[127:96];
      endcase
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    aes_sbox u_sbox (
      .in_byte (lane_in[8*i +: 8]),
      .out_byte(lane_out[8*i +: 8])
    );
  end

  // last_kw_q records who won the previous grant; a contested request goes to the other side.
  assign idle_ok = (state_q == IDLE) && !rst;
  assign st_gnt  = idle_ok && st_req && (!kw_req || last_kw_q);
  assign kw_gnt  = idle_ok && kw_req && (!st_req || !last_kw_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    st_op_d   = st_op_q;
    kw_op_d   = kw_op_q;
    st_out_d  = st_out_q;
    kw_out_d  = kw_out_q;
    st_done_d = 1'b0;
    kw_done_d = 1'b0;
    last_kw_d = last_kw_q;
    case (state_q)
      IDLE: begin
        if (st_gnt) begin
          st_op_d   = st_in;
          cnt_d     = 2'd0;
          last_kw_d = 1'b0;
          state_d   = ST_RUN;
        end else if (kw_gnt) begin
          kw_op_d   = kw_in;
          last_kw_d = 1'b1;
          state_d   = KW_RUN;
        end
      end
      ST_RUN: begin
        // Results overwrite the operand slice in place; the register holds the full result after pass 3.
        case (cnt_q)
          2'd0:    st_op_d[31:0]   = lane_out;
          2'd1:    st_op_d[63:32]  = lane_out;
          2'd2:    st_op_d[95:64]  = lane_out;
          default: st_op_d[127:96] = lane_out;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          st_out_d  = st_op_d;
          st_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      KW_RUN: begin
        kw_out_d  = lane_out;
        kw_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      st_op_q   <= '0;
      kw_op_q   <= '0;
      st_out_q  <= '0;
      kw_out_q  <= '0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
      last_kw_q <= (FIRST_PRIO == 0);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      st_op_q   <= st_op_d;
      kw_op_q   <= kw_op_d;
      st_out_q  <= st_out_d;
      kw_out_q  <= kw_out_d;
      st_done_q <= st_done_d;
      kw_done_q <= kw_done_d;
      last_kw_q <= last_kw_d;
    end
  end

  assign st_done = st_done_q;
  assign kw_done = kw_done_q;
  assign st_out  = st_out_q;
  assign kw_out  = kw_out_q;
  assign busy    = (state_q != IDLE);

endmodule
